// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package riscv_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of {instr, pc} entries between fetch and decode.
// The head entry is read straight from registered storage.
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  fetch_entry_t               wdata,
  output fetch_entry_t               rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t          mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // A pop in the flush cycle is simply dropped along with everything else.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push && !flush) mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives the instruction memory and queues
// {instr, pc} pairs for decode; redirects flush the queue and reload the PC.
module fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_rd,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4
);

  logic [31:0]            pc_q, pc_d;
  logic                   push, pop, full;
  logic [$clog2(DEPTH):0] count;
  fetch_entry_t           wdata, rdata;
  logic                   unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign pop   = id_valid & id_ready;
  // A full queue can still accept when the head leaves in the same cycle.
  assign push  = !redirect && (!full || pop);
  assign wdata = '{instr: imem_rd, pc: pc_q};

  always_comb begin
    pc_d = pc_q;
    if (redirect)  pc_d = {redirect_pc[31:2], 2'b00};
    else if (push) pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= {RESET_PC[31:2], 2'b00};
    else        pc_q <= pc_d;
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .count (count),
    .full  (full)
  );

  assign imem_a   = pc_q;
  assign id_valid = (count != '0);
  assign id_instr = rdata.instr;
  assign id_pc    = rdata.pc;
  assign id_pc4   = rdata.pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirect, PC wrap and async reset.
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_a, imem_rd;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc, id_pc4;

  int total = 0;
  int bad   = 0;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_a      (imem_a),
    .imem_rd     (imem_rd),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc4      (id_pc4)
  );

  always #5 clk = ~clk;

  assign imem_rd = imem_a ^ KEY;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Checks the head entry against an expected PC (instr derived from the memory model).
  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, ".valid"}, {31'd0, id_valid}, 32'd1);
    check({tag, ".pc"}, id_pc, pc);
    check({tag, ".instr"}, id_instr, pc ^ KEY);
    check({tag, ".pc4"}, id_pc4, pc + 32'd4);
  endtask

  task automatic reset_dut();
    rst_n    = 1'b0;
    redirect = 1'b0;
    id_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    id_ready    = 1'b0;
    #1;
    check("rst.valid", {31'd0, id_valid}, 32'd0);
    check("rst.imem_a", imem_a, 32'h0);
    check("rst.instr", id_instr, 32'h0);
    check("rst.pc", id_pc, 32'h0);
    check("rst.pc4", id_pc4, 32'h4);

    // 1: streaming with decode always ready
    reset_dut();
    id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_head($sformatf("stream%0d", k), 32'(4 * k));
    end

    // 2: decode stalls, queue fills and the PC freezes
    reset_dut();
    repeat (5) @(negedge clk);
    check("stall.imem_a", imem_a, 32'h8);
    check_head("stall.head", 32'h0);
    id_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_head($sformatf("drain%0d", k), 32'(4 * k));
    end

    // 3: redirect while full
    reset_dut();
    repeat (3) @(negedge clk);
    check("full.imem_a", imem_a, 32'h8);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(negedge clk);
    redirect = 1'b0;
    check("redir.valid", {31'd0, id_valid}, 32'd0);
    check("redir.imem_a", imem_a, 32'h100);
    @(negedge clk);
    check_head("redir.tgt", 32'h100);
    id_ready = 1'b1;
    @(negedge clk);
    check_head("redir.next", 32'h104);

    // 4: redirect and pop in the same cycle
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    @(negedge clk);
    redirect = 1'b0;
    check("rpop.valid", {31'd0, id_valid}, 32'd0);
    @(negedge clk);
    check_head("rpop.tgt", 32'h200);
    @(negedge clk);
    check_head("rpop.next", 32'h204);

    // 5: PC wrap
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect = 1'b0;
    check("wrap.valid", {31'd0, id_valid}, 32'd0);
    check("wrap.imem_a", imem_a, 32'hFFFF_FFF8);
    @(negedge clk);
    check_head("wrap.f8", 32'hFFFF_FFF8);
    @(negedge clk);
    check_head("wrap.fc", 32'hFFFF_FFFC);
    check("wrap.pc4", id_pc4, 32'h0);
    @(negedge clk);
    check_head("wrap.0", 32'h0);

    // 6: asynchronous reset mid-stream, off the clock edge
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst.valid", {31'd0, id_valid}, 32'd0);
    check("arst.imem_a", imem_a, 32'h0);
    check("arst.pc", id_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_head("arst.r0", 32'h0);
    @(negedge clk);
    check_head("arst.r1", 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
